module_timer_arb: RTL and testbench

- Round-robin arbiter and sequencer for one shared 24-bit cycle counter (the frequency-divider timebase).
- Up to NREQ requesters each ask for a timed interval of N clock cycles. The block grants the counter to one requester at a time, counts the interval, then pulses that requester's done.
- Used by the keypad-scan, debounce and display-refresh logic, so the design carries one wide counter instead of one per consumer.

---
 rtl/module_timer_arb.sv | 137 +++++++++++++
 tb/tb_module_timer_arb.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/module_timer_arb.sv
// Round-robin arbiter that lends one shared W-bit interval counter to NREQ requesters.
// Define TIMER_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module module_timer_arb #(
    parameter int NREQ = 4,
    parameter int W    = 24
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*W-1:0]   ncycles,
    output logic [NREQ-1:0]     grant,
    output logic [NREQ-1:0]     done,
    output logic                busy,
    output logic [W-1:0]        cuenta
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [W-1:0]    ONE_W     = {{(W-1){1'b0}}, 1'b1};
    localparam logic [NREQ-1:0] ONE_HOT_0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   owner_r;
    logic [W-1:0]    nlat_m1_r;
    logic [IW-1:0]   winner_s;
    logic            found_s;
    logic [W-1:0]    slice_s;
`ifndef TIMER_ARB_FIXED_PRIO_EN
    logic [IW-1:0]   last_r;
`endif

    // Winner selection among pending requests.
    always_comb begin
        winner_s = '0;
        found_s  = 1'b0;
`ifdef TIMER_ARB_FIXED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                winner_s = IW'(k);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
`else
        // Search starts just after the previous owner so it goes to the back of the line.
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last_r) + k) % NREQ]) begin
                winner_s = IW'((int'(last_r) + k) % NREQ);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
`endif
    end

    // Interval sampled from the winner's slice at grant time.
    always_comb begin
        slice_s = ncycles[int'(winner_s)*W +: W];
    end

    // Arbitration / counting sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            grant     <= '0;
            done      <= '0;
            busy      <= 1'b0;
            cuenta    <= '0;
            owner_r   <= '0;
            nlat_m1_r <= '0;
`ifndef TIMER_ARB_FIXED_PRIO_EN
            last_r    <= IW'(NREQ - 1);
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done   <= '0;
                    cuenta <= '0;
                    if (found_s) begin
                        grant   <= ONE_HOT_0 << winner_s;
                        busy    <= 1'b1;
                        owner_r <= winner_s;
                        // A zero interval is treated as one cycle, so Nlat-1 never underflows.
                        nlat_m1_r <= (slice_s == '0) ? '0 : (slice_s - ONE_W);
`ifndef TIMER_ARB_FIXED_PRIO_EN
                        last_r  <= winner_s;
`endif
                        state_r <= ST_COUNT;
                    end else begin
                        grant   <= '0;
                        busy    <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_COUNT: begin
                    // Abort outranks expiry on the same edge.
                    if (!req[owner_r]) begin
                        grant   <= '0;
                        done    <= '0;
                        busy    <= 1'b0;
                        cuenta  <= '0;
                        state_r <= ST_IDLE;
                    end else if (cuenta >= nlat_m1_r) begin
                        cuenta  <= '0;
                        done    <= grant;
                        state_r <= ST_DONE;
                    end else begin
                        cuenta  <= cuenta + ONE_W;
                        state_r <= ST_COUNT;
                    end
                end
                ST_DONE: begin
                    grant   <= '0;
                    done    <= '0;
                    busy    <= 1'b0;
                    cuenta  <= '0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    grant   <= '0;
                    done    <= '0;
                    busy    <= 1'b0;
                    cuenta  <= '0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_module_timer_arb.sv
// Directed bench for module_timer_arb with a grant-age reference model checked every cycle.
module tb_module_timer_arb;

    localparam int NREQ = 4;
    localparam int W    = 24;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [NREQ*W-1:0]   ncycles = '0;
    logic [NREQ-1:0]     grant;
    logic [NREQ-1:0]     done;
    logic                busy;
    logic [W-1:0]        cuenta;

    int total = 0;
    int bad   = 0;

    module_timer_arb #(.NREQ(NREQ), .W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ncycles (ncycles),
        .grant   (grant),
        .done    (done),
        .busy    (busy),
        .cuenta  (cuenta)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: owner plus cycles elapsed since its grant became visible.
    int m_owner = -1;
    int m_age   = 0;
    int m_nlat  = 1;
    int m_last  = NREQ - 1;
    bit m_valid = 1'b0;

    function automatic int pick(input logic [NREQ-1:0] r, input int last);
`ifdef TIMER_ARB_FIXED_PRIO_EN
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1; m_age = 0; m_nlat = 1; m_last = NREQ - 1; m_valid = 1'b1;
        end else if (m_valid) begin
            if (m_owner < 0) begin
                int w;
                w = pick(req, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_age   = 0;
                    m_nlat  = int'(ncycles[w*W +: W]);
                    if (m_nlat == 0) m_nlat = 1;
                    m_last  = w;
                end
            end else if (m_age < m_nlat && !req[m_owner]) begin
                m_owner = -1;
            end else begin
                m_age++;
                if (m_age > m_nlat) m_owner = -1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (m_valid) begin
            logic [NREQ-1:0] eg, ed;
            logic [W-1:0]    ec;
            eg = '0; ed = '0; ec = '0;
            if (m_owner >= 0) begin
                eg[m_owner] = 1'b1;
                if (m_age == m_nlat) ed[m_owner] = 1'b1;
                if (m_age < m_nlat) ec = W'(m_age);
            end
            check("model_grant",  32'(grant),  32'(eg));
            check("model_done",   32'(done),   32'(ed));
            check("model_busy",   32'(busy),   32'(m_owner >= 0));
            check("model_cuenta", 32'(cuenta), 32'(ec));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_n(input int i, input int v);
        ncycles[i*W +: W] = W'(v);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int order[5];
        int ng;
        int budget;
        logic [NREQ-1:0] prev;

        // Reset state.
        do_reset();
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_busy",  32'(busy),  32'h0);
        check("reset_cuenta", 32'(cuenta), 32'h0);

        // Single requester, interval 5.
        set_n(0, 5);
        req = 4'b0001;
        tick();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy",  32'(busy),  32'h1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t1_done_early", 32'(done), 32'h0);
        end
        tick();
        check("t1_done", 32'(done), 32'h1);
        check("t1_grant_hold", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();
        check("t1_release_grant", 32'(grant), 32'h0);
        check("t1_release_busy",  32'(busy),  32'h0);
        check("t1_release_done",  32'(done),  32'h0);
        tick();

        // All four requesting, interval 3 each.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_n(i, 3);
        req = 4'b1111;
        ng = 0;
        budget = 0;
        prev = '0;
        while (ng < 5 && budget < 100) begin
            tick();
            budget++;
            if (grant != '0 && prev == '0) begin
                for (int i = 0; i < NREQ; i++) if (grant[i]) order[ng] = i;
                ng++;
            end
            prev = grant;
        end
        check("t2_grant_count", 32'(ng), 32'd5);
        for (int g = 0; g < ng; g++) begin
`ifdef TIMER_ARB_FIXED_PRIO_EN
            check("t2_order", 32'(order[g]), 32'd0);
`else
            check("t2_order", 32'(order[g]), 32'(g % NREQ));
`endif
        end
        req = 4'b0000;
        tick(); tick(); tick(); tick(); tick();

        // Abort: owner 2 drops req after 4 counted cycles.
        do_reset();
        set_n(2, 10);
        req = 4'b0100;
        tick();
        check("t3_grant", 32'(grant), 32'h4);
        for (int i = 0; i < 4; i++) tick();
        check("t3_cuenta4", 32'(cuenta), 32'd4);
        req = 4'b0000;
        tick();
        check("t3_abort_grant",  32'(grant),  32'h0);
        check("t3_abort_busy",   32'(busy),   32'h0);
        check("t3_abort_cuenta", 32'(cuenta), 32'h0);
        check("t3_abort_done",   32'(done),   32'h0);
        tick(); tick(); tick();

        // Zero interval behaves as one.
        do_reset();
        set_n(1, 0);
        req = 4'b0010;
        tick();
        check("t4_grant", 32'(grant), 32'h2);
        tick();
        check("t4_done", 32'(done), 32'h2);
        req = 4'b0000;
        tick(); tick();

        // Interval is latched at grant; a later change is ignored.
        set_n(1, 8);
        req = 4'b0010;
        tick();
        check("t4b_grant", 32'(grant), 32'h2);
        set_n(1, 2);
        for (int i = 1; i <= 7; i++) begin
            tick();
            check("t4b_done_early", 32'(done), 32'h0);
        end
        tick();
        check("t4b_done", 32'(done), 32'h2);
        req = 4'b0000;
        tick(); tick();

        // Reset in the middle of a count, then requester 1 wins first.
        do_reset();
        set_n(0, 20);
        req = 4'b0001;
        tick();
        for (int i = 0; i < 7; i++) tick();
        check("t5_cuenta7", 32'(cuenta), 32'd7);
        rst = 1'b1;
        tick();
        check("t5_rst_grant",  32'(grant),  32'h0);
        check("t5_rst_busy",   32'(busy),   32'h0);
        check("t5_rst_cuenta", 32'(cuenta), 32'h0);
        check("t5_rst_done",   32'(done),   32'h0);
        rst = 1'b0;
        set_n(1, 2);
        set_n(3, 2);
        req = 4'b1010;
        tick();
        check("t5_first_grant", 32'(grant), 32'h2);
        for (int i = 0; i < 12; i++) tick();
        req = 4'b0000;
        tick(); tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
